// File: rtl/mem_responder.sv
// mem_responder: word-wide memory responder for the multicycle RISC-V core.
// It services one MemRead/MemWrite access at a time and inserts WAIT_CYCLES
// busy cycles before the access. Completion is signalled by a one-cycle
// mem_ready pulse. A misaligned access never touches the array; it only
// raises misaligned together with mem_ready.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for MemRead | MemWrite; request latched on accept
//   BUSY  | counting down cnt; access performed at the edge where cnt == 1
//   DONE  | single cycle with mem_ready high; requests are not sampled
module mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_ready,
  output logic        misaligned
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

  logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;

  logic                  req;
  logic                  do_access;
  logic                  acc_write;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic                  aligned;
  logic [ADDR_WIDTH-1:0] index;
  logic                  unused_addr_bits;

  // With no wait cycles the access happens on the accepting edge straight
  // from the ports; otherwise it uses the values latched on accept.
  always_comb begin
    req       = MemRead | MemWrite;
    do_access = 1'b0;
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (NO_WAIT && (state == IDLE) && req) begin
      do_access = 1'b1;
      acc_write = MemWrite;
      acc_addr  = addr;
      acc_wdata = write_data;
    end else if ((state == BUSY) && (cnt == 4'd1)) begin
      do_access = 1'b1;
    end
  end

  // Upper address bits are dropped so addresses wrap around the array.
  assign aligned          = (acc_addr[1:0] == 2'b00);
  assign index            = acc_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^acc_addr[31:ADDR_WIDTH+2];

  // Control FSM: accept, count down the wait, then one DONE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= write_data;
            write_q <= MemWrite;
            if (NO_WAIT) begin
              state <= DONE;
            end else begin
              cnt   <= WAIT_LOAD;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Registered outputs; mem_ready mirrors entry into DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data  <= 32'd0;
      mem_ready  <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      mem_ready <= do_access;
      if (do_access) begin
        misaligned <= ~aligned;
        if (aligned && !acc_write) read_data <= mem[index];
      end else if (state == DONE) begin
        misaligned <= 1'b0;
      end
    end
  end

  // Array write; the contents survive reset, and a write held off by reset is dropped.
  always_ff @(posedge clk) begin
    if (do_access && !reset && acc_write && aligned) mem[index] <= acc_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: one instance with no wait cycles (sel 0)
// and one with three wait cycles (sel 1), driven by directed steps.
module tb_mem_responder;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       rd;
  logic [1:0]       wr;
  logic [1:0][31:0] ad;
  logic [1:0][31:0] wd;
  logic [1:0][31:0] rdata;
  logic [1:0]       rdy;
  logic [1:0]       mis;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .MemRead(rd[0]), .MemWrite(wr[0]),
    .addr(ad[0]), .write_data(wd[0]), .read_data(rdata[0]),
    .mem_ready(rdy[0]), .misaligned(mis[0])
  );

  mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .MemRead(rd[1]), .MemWrite(wr[1]),
    .addr(ad[1]), .write_data(wd[1]), .read_data(rdata[1]),
    .mem_ready(rdy[1]), .misaligned(mis[1])
  );

  typedef struct {
    int          sel;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model   [2][256];
  logic [31:0] last_rd [2];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access: drive for one edge, predict into the scoreboard, then wait
  // for mem_ready, compare, and confirm the pulse lasts a single cycle.
  task automatic access(input int sel, input bit do_rd, input bit do_wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input int waitc, input bit scramble);
    exp_t       e;
    int         cyc;
    logic [7:0] idx;
    @(negedge clk);
    rd[sel] = do_rd;
    wr[sel] = do_wr;
    ad[sel] = a;
    wd[sel] = d;
    idx     = a[9:2];
    e.sel   = sel;
    e.mis   = (a[1:0] != 2'b00);
    if (!e.mis) begin
      if (do_wr) model[sel][idx] = d;
      else       last_rd[sel]    = model[sel][idx];
    end
    e.data = last_rd[sel];
    sb.push_back(e);
    @(posedge clk);
    #1;
    rd[sel] = 1'b0;
    wr[sel] = 1'b0;
    cyc = 0;
    while (cyc <= 40) begin
      @(negedge clk);
      if (rdy[sel]) break;
      cyc++;
      if (scramble) begin
        ad[sel] = $urandom;
        wd[sel] = $urandom;
      end
    end
    check("latency", cyc, waitc);
    e = sb.pop_front();
    check("rdata", rdata[e.sel], e.data);
    check("misaligned", {31'd0, mis[e.sel]}, {31'd0, e.mis});
    @(negedge clk);
    check("ready_one_cycle", {31'd0, rdy[sel]}, 32'd0);
    check("misaligned_clear", {31'd0, mis[sel]}, 32'd0);
    check("rdata_hold", rdata[sel], e.data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int cyc;
    int last_pulse;

    reset      = 1'b1;
    rd         = '0;
    wr         = '0;
    ad         = '0;
    wd         = '0;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    #12;
    for (int s = 0; s < 2; s++) begin
      check("reset_rdata", rdata[s], 32'd0);
      check("reset_ready", {31'd0, rdy[s]}, 32'd0);
      check("reset_mis", {31'd0, mis[s]}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Zero-wait write then read.
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b0);

    // Three-wait write then read, address/data churned while busy.
    access(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3, 1'b0);
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b1);

    // Misaligned write is suppressed; misaligned read on the waiting instance.
    access(0, 1'b0, 1'b1, 32'h13, 32'h12345678, 0, 1'b0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    access(1, 1'b1, 1'b0, 32'h11, 32'h0, 3, 1'b0);

    // Address wrap: 0x400 aliases word 0.
    access(0, 1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 0, 1'b0);
    access(0, 1'b1, 1'b0, 32'h000, 32'h0, 0, 1'b0);

    // Reset in the second BUSY cycle aborts a pending write.
    @(negedge clk);
    wr[1] = 1'b1;
    ad[1] = 32'h10;
    wd[1] = 32'h0;
    @(posedge clk);
    #1;
    wr[1] = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_rdata", rdata[1], 32'd0);
    check("async_rst_ready", {31'd0, rdy[1]}, 32'd0);
    check("async_rst_mis", {31'd0, mis[1]}, 32'd0);
    check("async_rst_rdata0", rdata[0], 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy[1]) pulses++;
    end
    check("aborted_no_ready", pulses, 0);
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b0);

    // Both strobes high: the write wins.
    for (int s = 0; s < 2; s++) begin
      access(s, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, (s == 0) ? 0 : 3, 1'b0);
      access(s, 1'b1, 1'b0, 32'h20, 32'h0, (s == 0) ? 0 : 3, 1'b0);
    end

    // MemRead held high: one pulse every WAIT_CYCLES + 2 cycles.
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      rd[s]      = 1'b1;
      ad[s]      = 32'h20;
      pulses     = 0;
      cyc        = 0;
      last_pulse = 0;
      while (pulses < 4 && cyc < 60) begin
        @(negedge clk);
        cyc++;
        if (rdy[s]) begin
          check("held_rdata", rdata[s], 32'hA5A5A5A5);
          if (pulses > 0) check("held_period", cyc - last_pulse, (s == 0) ? 2 : 5);
          last_pulse = cyc;
          pulses++;
        end
      end
      check("held_pulses", pulses, 4);
      rd[s] = 1'b0;
      @(negedge clk);
      check("held_stop", {31'd0, rdy[s]}, 32'd0);
    end

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Unified instruction/data memory responder for the multicycle RISC-V core. It sits on the memory side of the control FSM's `MemRead`/`MemWrite`/address interface and services one word access at a time. Each access takes a configurable number of wait cycles and is acknowledged with a one-cycle `mem_ready` pulse. It also flags misaligned word accesses and suppresses them.

## Interface

Parameters:
- `ADDR_WIDTH`, 8: log2 of the word count; the array holds 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, 0: number of BUSY cycles inserted before the access is performed; legal range 0–15.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `MemRead` input 1: read request, level-sensitive.
- `MemWrite` input 1: write request, level-sensitive.
- `addr` input 32: byte address.
- `write_data` input 32: store data.
- `read_data` output 32: registered load data.
- `mem_ready` output 1: access-complete pulse.
- `misaligned` output 1: the completed access had `addr[1:0]` != 0.

## Operation

- States: IDLE, BUSY, DONE. A 4-bit wait counter `cnt` is used in BUSY.
- IDLE:
  - A request is `MemRead | MemWrite` sampled at a rising edge.
  - On a request, latch `addr`, `write_data` and the op. Write has priority when both are high.
  - If `WAIT_CYCLES` == 0: perform the access at that same edge and go to DONE.
  - Otherwise: load `cnt = WAIT_CYCLES` and go to BUSY.
- BUSY:
  - `cnt` decrements every edge.
  - At the edge where `cnt` == 1: perform the access using the latched values and go to DONE.
  - Input changes during BUSY are ignored.
- DONE: lasts exactly one cycle, then IDLE. Requests are not sampled in DONE.
- Access:
  - Word index = latched `addr[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so addresses wrap modulo 4·2^ADDR_WIDTH bytes.
  - Read: `read_data` <= `mem[index]`.
  - Write: `mem[index]` <= latched `write_data`; `read_data` is unchanged.
  - Misaligned (`addr[1:0]` != 0): no array read or write, `read_data` is unchanged, and `misaligned` is set.
- `mem_ready` = (state == DONE).
- `misaligned` is registered. It is set at the access edge and cleared on the DONE→IDLE edge, so it is only ever high together with `mem_ready`.
- A request held high through DONE starts a new access in the following IDLE cycle. Back-to-back throughput is one access per `WAIT_CYCLES` + 2 cycles.
- Reset:
  - Asynchronously forces: state = IDLE, `cnt` = 0, `read_data` = 0, `mem_ready` = 0, `misaligned` = 0.
  - Does not clear the array.
  - Reset during BUSY aborts the access; a pending write is never committed.

## Timing

- Request sampled at edge N: access performed at edge N+`WAIT_CYCLES`.
- `mem_ready`, valid `read_data` and `misaligned` are all high or valid in the cycle following that edge, for exactly one cycle.
- `read_data` holds its value until the next completed aligned read or reset.
- All outputs are register-driven with no combinational input→output path.

## Test plan

1. `WAIT_CYCLES`=0: write 0xDEADBEEF to 0x10, then read 0x10 → `mem_ready` is high one cycle after each accepting edge, and `read_data` = 0xDEADBEEF after the read; IDLE/DONE alternation is confirmed.
2. `WAIT_CYCLES`=3: read 0x10 accepted at edge N → `mem_ready` is low through edge N+2 and high only in the cycle after edge N+3. Toggling `addr` during BUSY does not change the result.
3. Misaligned write of 0x12345678 to 0x13 → `misaligned`=1 and `mem_ready`=1 for one cycle; a subsequent read of 0x10 still returns 0xDEADBEEF.
4. Wrap-around with `ADDR_WIDTH`=8: write 0xCAFEF00D to 0x400, then read 0x000 → `read_data` = 0xCAFEF00D.
5. Reset mid-access with `WAIT_CYCLES`=3: write 0x0 to 0x10, assert `reset` in the second BUSY cycle → all outputs read 0 immediately (async). After release, a read of 0x10 returns 0xDEADBEEF and no `mem_ready` pulse from the aborted write appears.
6. `MemRead` and `MemWrite` both high with `write_data`=0xA5A5A5A5 at 0x20 → a write is performed and `read_data` is unchanged; a following read of 0x20 returns 0xA5A5A5A5. `MemRead` held high continuously gives one `mem_ready` pulse every `WAIT_CYCLES`+2 cycles.
